lcd_pattern_gen: RTL and testbench

Parametrised RGB test-pattern and cursor-overlay generator for the parallel TFT LCD path. It sits between the LCD timing generator and the panel colour pins. It consumes pixel coordinates, the active-video enable and the per-frame strobe, and produces registered RGB pixel data. It replaces the fixed 480×272 checkerboard and moving-tile logic with four selectable patterns, configurable panel and tile geometry, frame-synchronous mode switching and a rate-controlled tile cursor, all in the pixel-clock domain.

---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_tile_cursor.sv | 50 +++++
 rtl/lcd_pattern_gen.sv | 137 +++++++++++++
 tb/tb_lcd_pattern_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD test-pattern generator: mode encodings,
// RGB565 channel widths and the tile-count helper.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_CHECKER  = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_BORDER   = 2'd3
    } mode_t;

    localparam int RGB565_R_W = 5;
    localparam int RGB565_G_W = 6;
    localparam int RGB565_B_W = 5;

    // Number of tiles needed to cover a panel dimension, rounding up.
    function automatic int tiles_ceil(input int pixels, input int log2_edge);
        return (pixels + (1 << log2_edge) - 1) >> log2_edge;
    endfunction

endpackage

// File: rtl/lcd_tile_cursor.sv
// Tile cursor: frame divider plus raster stepping with wrap; pause freezes
// both the divider and the position.
module lcd_tile_cursor #(
    parameter int TILES_X  = 60,
    parameter int TILES_Y  = 34,
    parameter int STEP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic       pause,
    output logic [6:0] tile_x,
    output logic [6:0] tile_y
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [6:0]       tx_q;
    logic [6:0]       ty_q;
    logic             advance;
    logic             div_wrap;

    assign advance  = frame && !pause;
    assign div_wrap = (div_q == DIV_W'(STEP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            tx_q  <= '0;
            ty_q  <= '0;
        end else if (advance) begin
            if (div_wrap) begin
                div_q <= '0;
                if (tx_q == 7'(TILES_X - 1)) begin
                    tx_q <= '0;
                    ty_q <= (ty_q == 7'(TILES_Y - 1)) ? 7'd0 : ty_q + 7'd1;
                end else begin
                    tx_q <= tx_q + 7'd1;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign tile_x = tx_q;
    assign tile_y = ty_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Registered RGB test-pattern generator with frame-synchronous mode switching.
// Define LCD_PATTERN_CURSOR_EN to add the stepping red tile cursor overlay.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE  = 480,
    parameter int V_ACTIVE  = 272,
    parameter int COORD_W   = 10,
    parameter int TILE_LOG2 = 3,
    parameter int BAR_LOG2  = 6,
    parameter int R_W       = RGB565_R_W,
    parameter int G_W       = RGB565_G_W,
    parameter int B_W       = RGB565_B_W,
    parameter int STEP_DIV  = 1
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_en,
    input  logic [COORD_W-1:0] in_pixelx,
    input  logic [COORD_W-1:0] in_pixely,
    input  logic               in_frame,
    input  logic [1:0]         in_mode,
    input  logic               in_pause,
    output logic [R_W-1:0]     out_r,
    output logic [G_W-1:0]     out_g,
    output logic [B_W-1:0]     out_b,
    output logic               out_valid,
    output logic [6:0]         out_tilex,
    output logic [6:0]         out_tiley
);

    localparam logic [R_W-1:0] R_FULL = '1;
    localparam logic [G_W-1:0] G_FULL = '1;
    localparam logic [B_W-1:0] B_FULL = '1;
    localparam logic [R_W-1:0] R_HALF = {1'b0, {(R_W-1){1'b1}}};
    localparam logic [G_W-1:0] G_HALF = {1'b0, {(G_W-1){1'b1}}};
    localparam logic [B_W-1:0] B_HALF = {1'b0, {(B_W-1){1'b1}}};

    mode_t          mode_q;
    logic [R_W-1:0] r_next;
    logic [G_W-1:0] g_next;
    logic [B_W-1:0] b_next;
    logic           on_border;

    // Mode only changes on the frame strobe so a frame is never torn.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            mode_q <= MODE_CHECKER;
        end else if (in_frame) begin
            mode_q <= mode_t'(in_mode);
        end
    end

`ifdef LCD_PATTERN_CURSOR_EN
    localparam int TILES_X = tiles_ceil(H_ACTIVE, TILE_LOG2);
    localparam int TILES_Y = tiles_ceil(V_ACTIVE, TILE_LOG2);

    logic on_cursor;

    lcd_tile_cursor #(
        .TILES_X  (TILES_X),
        .TILES_Y  (TILES_Y),
        .STEP_DIV (STEP_DIV)
    ) u_cursor (
        .clk    (in_clk),
        .rst    (in_rst),
        .frame  (in_frame),
        .pause  (in_pause),
        .tile_x (out_tilex),
        .tile_y (out_tiley)
    );

    assign on_cursor = ((in_pixelx >> TILE_LOG2) == COORD_W'(out_tilex)) &&
                       ((in_pixely >> TILE_LOG2) == COORD_W'(out_tiley));
`else
    logic unused_pause;

    assign unused_pause = in_pause;
    assign out_tilex    = '0;
    assign out_tiley    = '0;
`endif

    assign on_border = (in_pixelx == '0) || (in_pixelx == COORD_W'(H_ACTIVE - 1)) ||
                       (in_pixely == '0) || (in_pixely == COORD_W'(V_ACTIVE - 1));

    always_comb begin
        r_next = '0;
        g_next = '0;
        b_next = '0;
        case (mode_q)
            MODE_CHECKER: begin
                r_next = (in_pixelx[TILE_LOG2]   ^ in_pixely[TILE_LOG2])   ? R_HALF : '0;
                g_next = (in_pixelx[TILE_LOG2+1] ^ in_pixely[TILE_LOG2+1]) ? G_HALF : '0;
                b_next = (in_pixelx[TILE_LOG2+2] ^ in_pixely[TILE_LOG2+2]) ? B_HALF : '0;
            end
            MODE_BARS: begin
                r_next = in_pixelx[BAR_LOG2+2] ? R_FULL : '0;
                g_next = in_pixelx[BAR_LOG2+1] ? G_FULL : '0;
                b_next = in_pixelx[BAR_LOG2]   ? B_FULL : '0;
            end
            MODE_GRADIENT: begin
                r_next = in_pixelx[COORD_W-1 -: R_W];
                g_next = in_pixely[COORD_W-1 -: G_W];
            end
            MODE_BORDER: begin
                if (on_border) begin
                    r_next = R_FULL;
                    g_next = G_FULL;
                    b_next = B_FULL;
                end
            end
            default: ;
        endcase
`ifdef LCD_PATTERN_CURSOR_EN
        if (on_cursor) begin
            r_next = R_FULL;
            g_next = '0;
            b_next = '0;
        end
`endif
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_en;
            out_r     <= in_en ? r_next : '0;
            out_g     <= in_en ? g_next : '0;
            out_b     <= in_en ? b_next : '0;
        end
    end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: directed pixels with hand-computed colours,
// checked by a cycle-tagged scoreboard; tile position checked against a frame count.
module tb_lcd_pattern_gen;

    localparam int STEP_DIV = 3;
`ifdef LCD_PATTERN_CURSOR_EN
    localparam bit CUR = 1'b1;
`else
    localparam bit CUR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [9:0] pixelx;
    logic [9:0] pixely;
    logic       frame;
    logic [1:0] mode;
    logic       pause;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic       valid;
    logic [6:0] tilex;
    logic [6:0] tiley;

    logic [16:0] exp_q[$];
    int          tag_q[$];
    int          cyc    = 0;
    int          frames = 0;
    int          tests  = 0;
    int          fails  = 0;

    lcd_pattern_gen #(.STEP_DIV(STEP_DIV)) dut (
        .in_clk    (clk),
        .in_rst    (rst),
        .in_en     (en),
        .in_pixelx (pixelx),
        .in_pixely (pixely),
        .in_frame  (frame),
        .in_mode   (mode),
        .in_pause  (pause),
        .out_r     (r),
        .out_g     (g),
        .out_b     (b),
        .out_valid (valid),
        .out_tilex (tilex),
        .out_tiley (tiley)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1; en = 1'b0; pixelx = '0; pixely = '0;
        frame = 1'b0; mode = 2'd0; pause = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] pk(input logic [4:0] er, input logic [5:0] eg,
                                       input logic [4:0] eb, input logic ev);
        return {er, eg, eb, ev};
    endfunction

    localparam logic [16:0] BLANK = 17'h0;
    localparam logic [16:0] BLACK = {5'h00, 6'h00, 5'h00, 1'b1};
    localparam logic [16:0] WHITE = {5'h1F, 6'h3F, 5'h1F, 1'b1};
    localparam logic [16:0] RED   = {5'h1F, 6'h00, 5'h00, 1'b1};

    // driver
    task automatic drive(input logic dr, input int x, input int y, input logic de,
                         input logic df, input logic [1:0] dm, input logic dp,
                         input logic [16:0] exp);
        @(posedge clk);
        #1;
        rst = dr; pixelx = x[9:0]; pixely = y[9:0]; en = de;
        frame = df; mode = dm; pause = dp;
        exp_q.push_back(exp);
        tag_q.push_back(cyc + 1);
        if (df && !dr && !(CUR && dp)) frames = frames + 1;
    endtask

    task automatic pulses(input int n, input logic dp);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b1, 2'd3, dp, BLANK);
    endtask

    task automatic check_tile(input string name);
        int steps;
        logic [6:0] ex, ey;
        steps = frames / STEP_DIV;
        ex = CUR ? 7'(steps % 60) : 7'd0;
        ey = CUR ? 7'((steps / 60) % 34) : 7'd0;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 2'd3, 1'b0, BLANK);
        @(negedge clk);
        tests++;
        if (tilex !== ex || tiley !== ey) begin
            fails++;
            $display("FAIL tile_%s got=(%0d,%0d) want=(%0d,%0d)", name, tilex, tiley, ex, ey);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (tag_q.size() > 0 && tag_q[0] == cyc) begin
            logic [16:0] want;
            want = exp_q.pop_front();
            void'(tag_q.pop_front());
            tests++;
            if ({r, g, b, valid} !== want) begin
                fails++;
                $display("FAIL pixel cyc=%0d got r=%h g=%h b=%h v=%b want r=%h g=%h b=%h v=%b",
                         cyc, r, g, b, valid, want[16:12], want[11:6], want[5:1], want[0]);
            end
        end
    end

    initial begin
        // reset overrides a coincident frame strobe and mode request
        drive(1'b1, 8, 0, 1'b1, 1'b1, 2'd1, 1'b0, BLANK);
        drive(1'b1, 8, 0, 1'b1, 1'b1, 2'd1, 1'b0, BLANK);
        check_tile("reset");

        // checker, with mode=1 requested mid-frame (no strobe)
        drive(1'b0, 8,   0,  1'b1, 1'b0, 2'd1, 1'b0, pk(5'h0F, 6'h00, 5'h00, 1'b1));
        drive(1'b0, 8,   8,  1'b1, 1'b0, 2'd1, 1'b0, BLACK);
        drive(1'b0, 24,  40, 1'b1, 1'b0, 2'd1, 1'b0, pk(5'h00, 6'h1F, 5'h0F, 1'b1));
        drive(1'b0, 0,   0,  1'b1, 1'b0, 2'd1, 1'b0, CUR ? RED : BLACK);
        drive(1'b0, 136, 0,  1'b1, 1'b0, 2'd1, 1'b0, pk(5'h0F, 6'h00, 5'h00, 1'b1));

        // bars
        drive(1'b0, 0,   0,  1'b0, 1'b1, 2'd1, 1'b0, BLANK);
        drive(1'b0, 130, 0,  1'b1, 1'b0, 2'd1, 1'b0, pk(5'h00, 6'h3F, 5'h00, 1'b1));
        drive(1'b0, 0,   0,  1'b1, 1'b0, 2'd1, 1'b0, CUR ? RED : BLACK);
        drive(1'b0, 448, 9,  1'b1, 1'b0, 2'd1, 1'b0, WHITE);

        // gradient
        drive(1'b0, 0,   0,   1'b0, 1'b1, 2'd2, 1'b0, BLANK);
        drive(1'b0, 130, 200, 1'b1, 1'b0, 2'd2, 1'b0, pk(5'd4, 6'd12, 5'd0, 1'b1));

        // border; third strobe moves the cursor to (1,0)
        drive(1'b0, 0,   0,   1'b0, 1'b1, 2'd3, 1'b0, BLANK);
        drive(1'b0, 479, 100, 1'b1, 1'b0, 2'd3, 1'b0, WHITE);
        drive(1'b0, 478, 100, 1'b1, 1'b0, 2'd3, 1'b0, BLACK);
        drive(1'b0, 0,   50,  1'b1, 1'b0, 2'd3, 1'b0, WHITE);
        drive(1'b0, 5,   271, 1'b1, 1'b0, 2'd3, 1'b0, WHITE);
        drive(1'b0, 600, 300, 1'b1, 1'b0, 2'd3, 1'b0, BLACK);
        drive(1'b0, 8,   0,   1'b1, 1'b0, 2'd3, 1'b0, CUR ? RED : WHITE);
        drive(1'b0, 0,   0,   1'b0, 1'b0, 2'd3, 1'b0, BLANK);
        check_tile("first_step");

        // cursor stepping: 180 strobes total -> row wrap to (0,1)
        pulses(177, 1'b0);
        check_tile("row_wrap");
        pulses(5, 1'b1);
        check_tile("paused");
        pulses(3, 1'b0);
        check_tile("after_pause");
        pulses(STEP_DIV * 60 * 34 - frames, 1'b0);
        check_tile("full_wrap");

        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL timeout got=running want=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
